// File: rtl/feature_stream_tx.sv
// feature_stream_tx: streams one feature map from a word buffer as (data, channel) pairs; ports: clk, rst (async active-low), start, en, mem_rd_en/mem_addr/mem_rdata buffer read port, data_out/channel_out/valid_out stream, busy, done.
module feature_stream_tx #(
  parameter int N = 16,
  parameter int CHANNELS = 16,
  parameter int FEATURE_SIZE = 112,
  localparam int TOTAL = FEATURE_SIZE * FEATURE_SIZE * CHANNELS,
  localparam int ADDR_W = $clog2(TOTAL),
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N-1:0]      mem_rdata,
  output logic [N-1:0]      data_out,
  output logic [CW-1:0]     channel_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic ready, v1;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] ch1;
  logic last;
  assign mem_rd_en = (state == STREAM) && en;
  assign mem_addr = addr;
  assign last = addr == ADDR_W'(TOTAL - 1);
  assign busy = (state == STREAM) || (state == DRAIN);
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   state_n = (start && ready) ? STREAM : IDLE;
      STREAM: state_n = (mem_rd_en && last) ? DRAIN : STREAM;
      DRAIN:  state_n = v1 ? DRAIN : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ready <= 1'b0;
      addr <= '0;
      v1 <= 1'b0;
      ch1 <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      channel_out <= '0;
    end else begin
      ready <= 1'b1;
      if (state == IDLE && start && ready) addr <= '0;
      else if (mem_rd_en) addr <= addr + ADDR_W'(1);
      v1 <= mem_rd_en;
      ch1 <= addr[CW-1:0];
      valid_out <= v1;
      if (v1) begin
        data_out <= mem_rdata;
        channel_out <= ch1;
      end
    end
endmodule

// File: tb/tb_feature_stream_tx.sv
// tb_feature_stream_tx: randomized self-checking bench for feature_stream_tx against a frame-level reference model.
module tb_feature_stream_tx;
  localparam int TOTAL = 16;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, en = 1'b0;
  logic mem_rd_en, valid_out, busy, done;
  logic [3:0] mem_addr;
  logic [15:0] mem_rdata = '0, data_out;
  logic [1:0] channel_out;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  feature_stream_tx #(.N(16), .CHANNELS(4), .FEATURE_SIZE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .data_out(data_out), .channel_out(channel_out), .valid_out(valid_out),
    .busy(busy), .done(done)
  );
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 16'(mem_addr) + 16'h0100;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      en = $urandom_range(0, 1);
      #1;
      check("idle_busy", busy, 0);
      check("idle_rd", mem_rd_en, 0);
      check("idle_valid", valid_out, 0);
    end
  endtask
  // mode 0: en=1, 1: random en, 2: en low for first 5 cycles, 3: en low 3 cycles after 5th read,
  // 4: random en then reset at 8th valid word. extra: spurious starts while busy and in DONE cycle.
  task automatic run_frame(input int mode, input bit extra);
    int rd_idx = 0, seen = 0, hold = 0;
    int rd_cyc[$];
    bit fin = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (extra && (seen == TOTAL || $urandom_range(0, 3) == 0));
      case (mode)
        0: en = 1'b1;
        2: en = cyc >= 5;
        3: begin
          en = !(rd_idx == 5 && hold < 3);
          if (rd_idx == 5 && hold < 3) hold++;
        end
        default: en = $urandom_range(0, 3) != 0;
      endcase
      #1;
      if (mode == 4 && valid_out && seen == 7) begin
        rst = 1'b0;
        #1;
        check("abort_valid", valid_out, 0);
        check("abort_data", data_out, 0);
        check("abort_chan", channel_out, 0);
        check("abort_busy", busy, 0);
        check("abort_rd", mem_rd_en, 0);
        check("abort_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          check("abort_nodone", done, 0);
        end
        return;
      end
      check("busy", busy, cyc >= 1 && seen < TOTAL);
      check("done", done, seen == TOTAL);
      check("rd_gated", mem_rd_en && !en, 0);
      if (mem_rd_en) begin
        check("rd_addr", mem_addr, rd_idx);
        rd_idx++;
        rd_cyc.push_back(cyc);
      end
      if (valid_out) begin
        check("data", data_out, 32'h0100 + seen);
        check("chan", channel_out, seen % 4);
        if (rd_cyc.size() == 0) check("extra_word", 1, 0);
        else check("latency", cyc - rd_cyc.pop_front(), 2);
        seen++;
      end
      if (seen == TOTAL && done) fin = 1;
    end
    check("frame_done", fin, 1);
    check("frame_reads", rd_idx, TOTAL);
    check("frame_words", seen, TOTAL);
    if (extra) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check("done_start_ignored", busy, 0);
      check("done_pulse_single", done, 0);
    end
  endtask
  initial begin
    #2;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_chan", channel_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle_cycles(3);
    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(3, 0);
    idle_cycles(2);
    run_frame(0, 1);
    idle_cycles(2);
    run_frame(4, 0);
    run_frame(0, 0);
    idle_cycles(1);
    run_frame(2, 0);
    for (int k = 0; k < 6; k++) begin
      run_frame(1, k[0]);
      idle_cycles($urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
